ntp_timebase: RTL
=================

NTP_TIMEBASE -- requirements
Module: ntp_timebase

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, clocks per 1 us tick (range 2..255).
REQ-002 SHALL have parameter SIG_PERIOD, default 800_000_000, clocks per o_ntp_sig period (range 2..2^32-1).
REQ-003 SHALL have parameter N_CAP, default 2, number of timestamp capture channels (1..8).
REQ-004 SHALL have parameters INC_INT (default 4294), INC_REM (default 967296) and INC_MOD (default 1_000_000), which together define the per-tick increment INC_INT + INC_REM/INC_MOD.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port i_ntp_set, input, 64 bits: time value to load.
REQ-008 SHALL have port i_ntp_set_sig, input, 1 bit: load strobe, one cycle.
REQ-009 SHALL have port o_ntp_get, output, 64 bits: current NTP time, 32.32 fixed point.
REQ-010 SHALL have port o_ntp_sig, output, 1 bit: periodic one-cycle pulse.
REQ-011 SHALL have port i_cap_trig, input, N_CAP bits: per-channel capture strobe.
REQ-012 SHALL have port i_cap_ack, input, N_CAP bits: per-channel consume strobe.
REQ-013 SHALL have port o_cap_time, output, 64*N_CAP bits: captured time; channel k occupies bits [64k+63:64k].
REQ-014 SHALL have port o_cap_vld, output, N_CAP bits: capture held, per channel.
REQ-015 SHALL have port o_cap_ovf, output, N_CAP bits: sticky overrun flag, per channel.

Function
REQ-016 Tick counter SHALL count 0..CLK_DIV-1 and wrap; the tick event is the cycle in which the count equals CLK_DIV-1.
REQ-017 On each tick event, o_ntp_get SHALL increase by INC_INT + carry on the following cycle.
- carry = 1 when acc + INC_REM >= INC_MOD, in which case acc <= acc + INC_REM - INC_MOD.
- Otherwise carry = 0 and acc <= acc + INC_REM.
- acc is 20 bits wide.
REQ-018 o_ntp_get SHALL wrap modulo 2^64 with no flag.
REQ-019 i_ntp_set_sig SHALL, on the next cycle, load o_ntp_get with i_ntp_set and clear both the tick counter and acc.
- Takes priority over a same-cycle tick event; the increment is dropped.
REQ-020 The o_ntp_sig counter SHALL count 0..SIG_PERIOD-1, free-running; o_ntp_sig SHALL be 1 for exactly the cycle after the count reaches SIG_PERIOD-1.
- The counter is not affected by i_ntp_set_sig.
REQ-021 i_cap_trig[k] high SHALL, on the next cycle, store the pre-update o_ntp_get into channel k and set o_cap_vld[k].
- With a same-cycle set or tick event, the stored value is the old time.
REQ-022 i_cap_ack[k] while o_cap_vld[k]=1 SHALL clear o_cap_vld[k] next cycle; o_cap_time[k] SHALL hold its value.
REQ-023 i_cap_trig[k] while o_cap_vld[k]=1 and i_cap_ack[k]=0 SHALL overwrite the stored time and set o_cap_ovf[k]; o_cap_vld stays 1.
REQ-024 i_cap_trig[k] and i_cap_ack[k] in the same cycle SHALL capture the new value, keep o_cap_vld[k]=1 and leave o_cap_ovf[k] unchanged.
REQ-025 o_cap_ovf[k] SHALL clear only on an i_cap_ack[k] that is not accompanied by i_cap_trig[k], or on reset.
REQ-026 i_cap_ack[k] while o_cap_vld[k]=0 SHALL have no effect.
REQ-027 Channels SHALL operate independently and simultaneously.

Reset
REQ-028 i_rst high at a clock edge SHALL clear the following to 0 on that edge, overriding all other inputs:
- o_ntp_get, o_ntp_sig, o_cap_time, o_cap_vld, o_cap_ovf;
- the tick counter, acc and the sig counter.
REQ-029 Reset asserted mid-operation SHALL discard pending captures without setting o_cap_ovf.
- The first tick event after release SHALL occur CLK_DIV cycles after the first non-reset cycle.

Configuration
REQ-030 Macro NTP_FRAC_ACCUM_EN defined: the accumulator SHALL be implemented and the increment follows REQ-017, giving an exact 2^32 per 1_000_000 ticks.
REQ-031 Macro NTP_FRAC_ACCUM_EN undefined: acc SHALL be absent and every tick event SHALL add the constant INC_INT+1 (4295 at defaults).

Verification
REQ-032 Reset, then run 1_000_000 ticks at defaults with NTP_FRAC_ACCUM_EN -> o_ntp_get = 64'h0000_0001_0000_0000 exactly; without the macro -> o_ntp_get = 4_295_000_000.
REQ-033 Set 64'hFFFF_FFFF_FFFF_FFFF, then one tick -> o_ntp_get = 4293, with wrap and no flag.
REQ-034 Drive i_ntp_set_sig in the tick cycle with i_ntp_set = 64'h100 -> o_ntp_get = 64'h100; the next increment arrives 50 cycles later.
REQ-035 Trigger channel 0 twice without an ack -> o_cap_vld[0]=1, o_cap_ovf[0]=1 and the second time is held. Then assert trig and ack together -> ovf stays 1. Then ack alone -> vld=0, ovf=0.
REQ-036 SIG_PERIOD=10 -> o_ntp_sig pulses at cycles 10, 20 and 30 after reset release, unaffected by a set issued at cycle 15.
REQ-037 Assert i_rst at cycle 25 with o_cap_vld=2'b11 -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ntp_timebase.sv
// NTP 32.32 timebase with periodic pulse and per-channel timestamp capture.
// Define NTP_FRAC_ACCUM_EN to add the fractional-remainder accumulator (exact 2^32 per 10^6 ticks).
module ntp_timebase #(
  parameter int          CLK_DIV    = 50,
  parameter int unsigned SIG_PERIOD = 800_000_000,
  parameter int          N_CAP      = 2,
  parameter int          INC_INT    = 4294,
  parameter int          INC_REM    = 967296,
  parameter int          INC_MOD    = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [63:0]          i_ntp_set,
  input  logic                 i_ntp_set_sig,
  output logic [63:0]          o_ntp_get,
  output logic                 o_ntp_sig,
  input  logic [N_CAP-1:0]     i_cap_trig,
  input  logic [N_CAP-1:0]     i_cap_ack,
  output logic [64*N_CAP-1:0]  o_cap_time,
  output logic [N_CAP-1:0]     o_cap_vld,
  output logic [N_CAP-1:0]     o_cap_ovf
);

  localparam logic [7:0]  TICK_LAST = 8'(CLK_DIV - 1);
  localparam logic [31:0] SIG_LAST  = 32'(SIG_PERIOD - 1);

  logic [7:0]  tick_cnt_reg;
  logic [31:0] sig_cnt_reg;
  logic        sig_reg;
  logic [63:0] time_reg;
  logic [63:0] inc;
  logic        tick;

  assign tick = (tick_cnt_reg == TICK_LAST);

`ifdef NTP_FRAC_ACCUM_EN
  logic [19:0] acc_reg;
  logic [19:0] acc_next;
  logic [20:0] acc_sum;
  logic        carry;

  always_comb begin
    acc_sum  = {1'b0, acc_reg} + 21'(INC_REM);
    carry    = (acc_sum >= 21'(INC_MOD));
    acc_next = acc_sum[19:0];
    if (carry) begin
      acc_next = 20'(acc_sum - 21'(INC_MOD));
    end
  end

  assign inc = 64'(INC_INT) + {63'd0, carry};

  // A load restarts the fractional phase along with the tick counter.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_ntp_set_sig) begin
      acc_reg <= '0;
    end else if (tick) begin
      acc_reg <= acc_next;
    end
  end
`else
  assign inc = 64'(INC_INT + 1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_cnt_reg <= '0;
      sig_cnt_reg  <= '0;
      sig_reg      <= 1'b0;
      time_reg     <= '0;
    end else begin
      // The pulse counter free-runs and ignores time loads.
      sig_cnt_reg <= (sig_cnt_reg == SIG_LAST) ? '0 : sig_cnt_reg + 32'd1;
      sig_reg     <= (sig_cnt_reg == SIG_LAST);
      if (i_ntp_set_sig) begin
        time_reg     <= i_ntp_set;
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 8'd1;
        if (tick) begin
          time_reg <= time_reg + inc;
        end
      end
    end
  end

  assign o_ntp_get = time_reg;
  assign o_ntp_sig = sig_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CAP; gi++) begin : g_cap
      logic [63:0] cap_time_reg;
      logic        cap_vld_reg;
      logic        cap_ovf_reg;

      // Trigger wins over ack; overrun only when a held value is lost unacknowledged.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          cap_time_reg <= '0;
          cap_vld_reg  <= 1'b0;
          cap_ovf_reg  <= 1'b0;
        end else if (i_cap_trig[gi]) begin
          cap_time_reg <= time_reg;
          cap_vld_reg  <= 1'b1;
          if (cap_vld_reg && !i_cap_ack[gi]) begin
            cap_ovf_reg <= 1'b1;
          end
        end else if (i_cap_ack[gi] && cap_vld_reg) begin
          cap_vld_reg <= 1'b0;
          cap_ovf_reg <= 1'b0;
        end
      end

      assign o_cap_time[64*gi +: 64] = cap_time_reg;
      assign o_cap_vld[gi]           = cap_vld_reg;
      assign o_cap_ovf[gi]           = cap_ovf_reg;
    end
  endgenerate

endmodule
